// File: rtl/keypad_pkg.sv
// Shared key codes, keypad map and scanner state encoding for the keypad
// scanner and the calculator control FSM that consumes its key codes.
package keypad_pkg;

   localparam logic [3:0] EQUAL = 4'd10;
   localparam logic [3:0] AC    = 4'd11;
   localparam logic [3:0] PLUS  = 4'd12;
   localparam logic [3:0] MINUS = 4'd13;
   localparam logic [3:0] MULT  = 4'd14;
   localparam logic [3:0] DIV   = 4'd15;

   // Indexed by {row, col}
   localparam logic [3:0] KEYMAP [16] = '{
      4'd1, 4'd2, 4'd3,  PLUS,
      4'd4, 4'd5, 4'd6,  MINUS,
      4'd7, 4'd8, 4'd9,  MULT,
      AC,   4'd0, EQUAL, DIV
   };

   typedef enum logic [2:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT_RELEASE
   } scan_state_t;

   function automatic logic [1:0] lowest_zero(input logic [3:0] p);
      if (!p[0])      return 2'd0;
      else if (!p[1]) return 2'd1;
      else if (!p[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key strobe / key code link from the keypad scanner to the calculator FSM.
interface keypad_scanner_if;
   logic       kbEN;
   logic [3:0] pressedkey;

   modport master (output kbEN, output pressedkey);
   modport slave  (input  kbEN, input  pressedkey);
endinterface

// File: rtl/keypad_debounce.sv
// Stable-for-N detector: done is high on the Nth consecutive cycle of match.
module keypad_debounce #(
   parameter int N = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic match,
   output logic done
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] cnt;

   assign done = match && (cnt == W'(N - 1));

   // Saturates at N-1 so a long hold never wraps into a second done
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      cnt <= '0;
      else if (!match) cnt <= '0;
      else if (!done)  cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce and one kbEN strobe per press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
//
//   state           | meaning
//   ST_SCAN         | walk columns, sample rows at end of each column period
//   ST_DEBOUNCE     | column frozen, count stable press samples
//   ST_SETUP        | pressedkey valid, kbEN still low
//   ST_STROBE       | kbEN high for EN_PULSE_LEN cycles
//   ST_WAIT_RELEASE | column frozen, count stable all-released samples
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV      = 1000,
   parameter int DEBOUNCE_CNT  = 50000,
   parameter int EN_PULSE_LEN  = 4
`ifdef KEYPAD_REPEAT_EN
   , parameter int REPEAT_DELAY  = 25000000
   , parameter int REPEAT_PERIOD = 5000000
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        rows,
   output logic [3:0]        cols,
   keypad_scanner_if.master  kb
);

   localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int PL_W = (EN_PULSE_LEN > 1) ? $clog2(EN_PULSE_LEN) : 1;

   scan_state_t     state, state_nxt;
   logic [3:0]      rs_meta, rs;
   logic [1:0]      col, col_nxt, row_q, row_nxt;
   logic [3:0]      pat_q, pat_nxt, pk_q, pk_nxt;
   logic [SD_W-1:0] scan_cnt, scan_nxt;
   logic [PL_W-1:0] pulse_cnt, pulse_nxt;
   logic            press_done, rel_done;

   keypad_debounce #(.N(DEBOUNCE_CNT)) u_press_db (
      .clk   (clk),
      .reset (reset),
      .match ((state == ST_DEBOUNCE) && (rs == pat_q)),
      .done  (press_done)
   );

   keypad_debounce #(.N(DEBOUNCE_CNT)) u_release_db (
      .clk   (clk),
      .reset (reset),
      .match ((state == ST_WAIT_RELEASE) && (rs == 4'b1111)),
      .done  (rel_done)
   );

`ifdef KEYPAD_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic [RP_W-1:0] rep_cnt, rep_nxt;
   logic            rep_first, rep_first_nxt, rep_fire;

   // rep_cnt is zero on the cycle kbEN rises, so limits are rise-to-rise
   assign rep_fire = (state == ST_WAIT_RELEASE) && (rs == pat_q) &&
                     (rep_cnt >= (rep_first ? RP_W'(REPEAT_DELAY - 1)
                                            : RP_W'(REPEAT_PERIOD - 1)));
`endif

   assign cols           = ~(4'b0001 << col);
   assign kb.kbEN        = (state == ST_STROBE);
   assign kb.pressedkey  = pk_q;

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row_q;
      pat_nxt   = pat_q;
      pk_nxt    = pk_q;
      scan_nxt  = scan_cnt;
      pulse_nxt = pulse_cnt;
`ifdef KEYPAD_REPEAT_EN
      rep_first_nxt = rep_first;
      if (((state == ST_STROBE) || (state == ST_WAIT_RELEASE)) && (rs == pat_q))
         rep_nxt = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
      else
         rep_nxt = '0;
`endif
      case (state)
         ST_SCAN: begin
            if (scan_cnt == SD_W'(SCAN_DIV - 1)) begin
               scan_nxt = '0;
               if (rs != 4'b1111) begin
                  row_nxt   = lowest_zero(rs);
                  pat_nxt   = rs;
                  state_nxt = ST_DEBOUNCE;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end else begin
               scan_nxt = scan_cnt + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (rs != pat_q) begin
               state_nxt = ST_SCAN;
               col_nxt   = col + 2'd1;
            end else if (press_done) begin
               // Key code lands one cycle ahead of the kbEN rising edge
               state_nxt = ST_SETUP;
               pk_nxt    = KEYMAP[{row_q, col}];
            end
         end
         ST_SETUP: begin
            state_nxt = ST_STROBE;
            pulse_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_first_nxt = 1'b1;
`endif
         end
         ST_STROBE: begin
            if (pulse_cnt == PL_W'(EN_PULSE_LEN - 1)) begin
               state_nxt = ST_WAIT_RELEASE;
               pulse_nxt = '0;
            end else begin
               pulse_nxt = pulse_cnt + 1'b1;
            end
         end
         ST_WAIT_RELEASE: begin
            if (rel_done) begin
               state_nxt = ST_SCAN;
               col_nxt   = 2'd0;
               scan_nxt  = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_fire) begin
               state_nxt     = ST_STROBE;
               pulse_nxt     = '0;
               rep_nxt       = '0;
               rep_first_nxt = 1'b0;
            end
`endif
         end
         default: state_nxt = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rs_meta   <= 4'b1111;
         rs        <= 4'b1111;
         state     <= ST_SCAN;
         col       <= 2'd0;
         row_q     <= 2'd0;
         pat_q     <= 4'b1111;
         pk_q      <= 4'd0;
         scan_cnt  <= '0;
         pulse_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
         rep_first <= 1'b1;
`endif
      end else begin
         rs_meta   <= rows;
         rs        <= rs_meta;
         state     <= state_nxt;
         col       <= col_nxt;
         row_q     <= row_nxt;
         pat_q     <= pat_nxt;
         pk_q      <= pk_nxt;
         scan_cnt  <= scan_nxt;
         pulse_cnt <= pulse_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= rep_nxt;
         rep_first <= rep_first_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 key-matrix model.
module tb_keypad_scanner;

   logic        clk;
   logic        reset;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [15:0] keys;

   keypad_scanner_if kb ();

   keypad_scanner #(
      .SCAN_DIV     (4),
      .DEBOUNCE_CNT (8),
      .EN_PULSE_LEN (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rows  (rows),
      .cols  (cols),
      .kb    (kb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pressed key at (r,c) pulls row r low while column c is driven low
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[4*r + c] && !cols[c]) rows[r] = 1'b0;
   end

   typedef struct {
      logic [3:0] cols;
      logic       kben;
      logic [3:0] pk;
   } scan_vec_t;

   typedef struct {
      logic [15:0] keys;
      logic [3:0]  code;
      int          bounce;
      int          hold;
   } key_vec_t;

   scan_vec_t sv [20];
   key_vec_t  kv [8];

   int         checks = 0;
   int         errors = 0;
   int         rises  = 0;
   logic       kb_last = 1'b0;
   logic [3:0] pk_cur  = 4'd0;
   logic [3:0] pk_prev = 4'd0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (kb.kbEN && !kb_last) rises++;
      kb_last = kb.kbEN;
      pk_prev = pk_cur;
      pk_cur  = kb.pressedkey;
   endtask

   task automatic wait_strobe();
      int n;
      n = 0;
      while (!kb_last && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic press(input logic [15:0] k, input logic [3:0] code,
                        input int bounce, input int hold);
      int r0;
      int n;
      r0 = rises;
      for (int i = 0; i < bounce; i++) begin
         keys = (i % 2 == 0) ? k : 16'h0000;
         step();
      end
      keys = k;
      wait_strobe();
      chk("strobe_seen", kb_last, 1);
      chk("setup_code", pk_prev, code);
      chk("strobe_code", pk_cur, code);
      n = 0;
      while (kb_last && n < 20) begin
         step();
         n++;
      end
      chk("pulse_len", n, 2);
      repeat (hold) step();
      keys = 16'h0000;
      repeat (40) step();
      chk("one_strobe", rises - r0, 1);
      chk("pk_held", pk_cur, code);
   endtask

   initial begin
      logic [3:0] one;
      logic [3:0] prev_cols;
      int         n;
      int         r0;

      one = 4'b0001;
      for (int i = 0; i < 20; i++)
         sv[i] = '{~(one << ((i / 4) % 4)), 1'b0, 4'd0};

      kv[0] = '{16'h0040, 4'd6,  0, 40};
      kv[1] = '{16'h0001, 4'd1,  6, 40};
      kv[2] = '{16'h4000, 4'd10, 0, 20};
      kv[3] = '{16'h1000, 4'd11, 0, 20};
      kv[4] = '{16'h0808, 4'd12, 0, 200};
      kv[5] = '{16'h0200, 4'd8,  0, 20};
      kv[6] = '{16'h8000, 4'd15, 0, 20};
      kv[7] = '{16'h0080, 4'd13, 0, 20};

      keys  = 16'h0000;
      reset = 1'b1;
      #3 reset = 1'b0;
      repeat (3) step();
      chk("rst_cols", cols, 4'b1110);
      chk("rst_kben", kb.kbEN, 0);
      chk("rst_pk", kb.pressedkey, 0);

      // Idle scan: reset released mid-cycle, so this cycle is the first of col 0
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("scan_cols", cols, sv[i].cols);
         chk("scan_kben", kb.kbEN, sv[i].kben);
         chk("scan_pk", kb.pressedkey, sv[i].pk);
         step();
      end

      for (int i = 0; i < 8; i++)
         press(kv[i].keys, kv[i].code, kv[i].bounce, kv[i].hold);

      // Short glitch on row0/col1: debounce entered, aborted, scan moves to col2
      r0 = rises;
      prev_cols = cols;
      n = 0;
      step();
      while (!(cols == 4'b1101 && prev_cols == 4'b1110) && n < 50) begin
         prev_cols = cols;
         step();
         n++;
      end
      chk("glitch_align", cols, 4'b1101);
      keys = 16'h0002;
      repeat (5) step();
      keys = 16'h0000;
      repeat (2) step();
      chk("glitch_frozen", cols, 4'b1101);
      step();
      chk("glitch_next_col", cols, 4'b1011);
      repeat (4) step();
      chk("glitch_col3", cols, 4'b0111);
      repeat (30) step();
      chk("glitch_no_strobe", rises - r0, 0);

      // Reset during the second kbEN cycle, key kept held throughout
      keys = 16'h0040;
      wait_strobe();
      chk("pre_rst_strobe", kb_last, 1);
      step();
      chk("pre_rst_second", kb_last, 1);
      reset = 1'b0;
      #1;
      chk("midrst_kben", kb.kbEN, 0);
      chk("midrst_cols", cols, 4'b1110);
      chk("midrst_pk", kb.pressedkey, 0);
      repeat (3) step();
      reset = 1'b1;
      r0 = rises;
      wait_strobe();
      chk("post_rst_strobe", kb_last, 1);
      chk("post_rst_setup", pk_prev, 6);
      repeat (30) step();
      keys = 16'h0000;
      repeat (40) step();
      chk("post_rst_one", rises - r0, 1);
      chk("post_rst_pk", pk_cur, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
